hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised multi-cycle hazard scoreboard for the ID stage. It replaces the fixed EX/MEM compare stall logic.
//  - Tracks, per architectural register, the cycles left until its pending result can be bypassed.
//  - Variable result latency: ALU, load, mul, div.
//  - Raises stall on RAW and WAW hazards.
//  - Cancels pending writes of squashed instructions by issue age on branch correction.
// PARAMETERS
//  NREG     32               number of architectural registers; r0 is never tracked
//  ADDR_W   $clog2(NREG)     register index width
//  LAT_W    3                latency field width; max latency 2**LAT_W-1
//  SEQ_W    6                issue-sequence tag width; must be >= LAT_W+2
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       asynchronous active-low reset
//  id_valid      in   1       instruction present in ID
//  id_rs         in   ADDR_W  source 1 index
//  id_rt         in   ADDR_W  source 2 index
//  id_rs_used    in   1       source 1 is read
//  id_rt_used    in   1       source 2 is read
//  id_dst        in   ADDR_W  destination index
//  id_wen        in   1       instruction writes id_dst
//  id_lat        in   LAT_W   cycles a dependant must wait (0 = fully bypassable)
//  hold          in   1       downstream freeze (e.g. memory wait)
//  flush_valid   in   1       branch correction this cycle
//  flush_cnt     in   SEQ_W   number of youngest issued instructions to kill
//  stall         out  1       ID must not advance
//  id_fire       out  1       instruction issues this cycle
//  busy_mask     out  NREG    registered: bit i = cnt[i]!=0; bit 0 always 0
// BEHAVIOUR
//  State per register i>0: cnt[i] (LAT_W), tag[i] (SEQ_W). Global seq (SEQ_W) = tag of the next issue.
//  Reset: all cnt=0, all tag=0, seq=0, busy_mask=0. Perf counters (if built) reset to 0.
//  Hazard terms (combinational):
//    raw = (id_rs_used & id_rs!=0 & cnt[id_rs]!=0) | (id_rt_used & id_rt!=0 & cnt[id_rt]!=0)
//    waw = id_wen & id_dst!=0 & cnt[id_dst]>id_lat
//    stall = id_valid & (raw|waw|hold)
//    id_fire = id_valid & ~stall & ~flush_valid   (a flush squashes the ID instruction)
//  Per clock edge, priority high to low, per entry:
//    1 Flush kill: flush_valid & cnt!=0 & 1 <= (seq-tag) mod 2**SEQ_W <= flush_cnt -> cnt=0.
//    2 Issue: id_fire & id_wen & id_dst==i & id_lat!=0 -> cnt=id_lat, tag=seq.
//      A new issue overrides the decrement on that entry in the same cycle.
//    3 Countdown: else if ~hold & cnt!=0 -> cnt-1.
//  seq increments by 1 (mod 2**SEQ_W) on every id_fire, including id_wen=0.
//  Age: youngest issued instruction has age 1. flush_cnt=0 is a no-op.
//  hold: freezes all countdowns. Flush kill still applies. id_fire=0.
//  id_lat=0 or id_dst=0: no entry written. seq still advances.
//  Latency: a dependant of an issue with id_lat=N stalls exactly N cycles when hold=0.
//  busy_mask reflects post-edge cnt, so it is one cycle behind the combinational stall inputs.
//  Reset mid-operation: all pending state is discarded immediately (asynchronous).
// CONFIGURATION
//  HAZARD_SB_PERF_EN defined: adds two outputs.
//    perf_raw_stalls [31:0]: +1 per cycle with id_valid & raw.
//    perf_waw_stalls [31:0]: +1 per cycle with id_valid & waw & ~raw.
//    Both saturate at 32'hFFFF_FFFF.
//  HAZARD_SB_PERF_EN undefined: the perf ports and counters are absent. Functional behaviour is identical.
// STRUCTURE
//  Package hazard_sb_pkg:
//    LAT_ALU=0, LAT_LOAD=1, LAT_MUL=4, LAT_DIV=7
//    typedef sb_entry_t {cnt, tag}
//    function age_in_window(seq, tag, flush_cnt)
//  Sub-module sb_entry: one cnt/tag cell with kill/issue/countdown priority. Generate NREG-1 instances (r1..).
//  Top level: seq counter, hazard muxes, perf counters.
// TESTING
//  1 Load r5 lat 1, then reader of r5: stall=1 for 1 cycle, id_fire on the 2nd cycle; busy_mask[5] high 1 cycle.
//  2 Mul r8 lat 4, then reader of r8: stall for 4 cycles, then fire. ALU lat 0 reader: no stall.
//  3 WAW: mul r8 lat 4, next cycle load r8 lat 1: stall until cnt[8]<=1 (3 cycles), then cnt[8]=1, tag = new seq.
//  4 Flush: mul r9 lat 4, then ALU r3 issue, then flush_cnt=2: cnt[9]=0 next edge; reader of r9 fires at once.
//    ID instruction in the flush cycle: id_fire=0.
//  5 Flush window: mul r9 lat 4, then 2 more issues, then flush_cnt=2: r9 survives (age 3) and keeps counting.
//  6 Hold 2 cycles while cnt[8]=3: cnt stays 3, stall=1. Then 3 more cycles to clear.
//    r0 dst lat 7: busy_mask=0.
//    Seq wrap after 64 issues: flush_cnt=1 kills only the youngest.
//    Async reset mid-countdown: busy_mask=0 immediately.
//  7 (HAZARD_SB_PERF_EN) Scenario 2: perf_raw_stalls=4. Scenario 3: perf_waw_stalls=3.

Source files
------------

// File: rtl/hazard_sb_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: unit latencies,
// default geometry, the per-register entry record and the flush-age test.
package hazard_sb_pkg;

    // Cycles a dependant must wait behind each functional unit.
    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 4;
    localparam int unsigned LAT_DIV  = 7;

    // Default field widths; the scoreboard parameters start from these.
    localparam int unsigned SB_LAT_W = 3;
    localparam int unsigned SB_SEQ_W = 6;

    // One tracked register: remaining latency and issue tag of its producer.
    typedef struct packed {
        logic [SB_LAT_W-1:0] cnt;
        logic [SB_SEQ_W-1:0] tag;
    } sb_entry_t;

    // True when the producer tagged 'tag' is among the 'flush_cnt' youngest
    // issues. seq is the tag of the next issue, so the youngest has age 1;
    // the subtraction wraps modulo 2**seq_w.
    function automatic logic age_in_window(input int unsigned seq,
                                           input int unsigned tag,
                                           input int unsigned flush_cnt,
                                           input int unsigned seq_w);
        int unsigned age;
        age = (seq - tag) & ((32'd1 << seq_w) - 32'd1);
        return (age != 0) && (age <= flush_cnt);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// sb_entry: one scoreboard cell (countdown + issue tag) for a single
// architectural register. Priority per edge: flush kill, issue, countdown.
module sb_entry
    import hazard_sb_pkg::*;
#(
    parameter int unsigned LAT_W = SB_LAT_W,
    parameter int unsigned SEQ_W = SB_SEQ_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [SEQ_W-1:0] i_seq,
    input  logic [SEQ_W-1:0] i_flush_cnt,
    input  logic             i_issue,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_hold,
    output logic [LAT_W-1:0] o_cnt
);

    logic [LAT_W-1:0] r_cnt;
    logic [SEQ_W-1:0] r_tag;
    logic             w_kill;

    // A pending write dies when its producer is one of the squashed issues.
    assign w_kill = i_flush && (r_cnt != '0) &&
                    age_in_window(32'(i_seq), 32'(r_tag), 32'(i_flush_cnt), SEQ_W);

    // Kill beats a new issue, which beats the countdown; hold freezes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag is reset with the counter even though it is only
            // read while cnt!=0, so the cell leaves reset in a known state.
            r_cnt <= '0;
            r_tag <= '0;
        end else if (w_kill) begin
            // NOTE: non-blocking assignments here so every cell samples the
            // same pre-edge seq and counter values regardless of block order.
            r_cnt <= '0;
        end else if (i_issue) begin
            r_cnt <= i_lat;
            r_tag <= i_seq;
        end else if (!i_hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: multi-cycle RAW/WAW hazard scoreboard for the ID stage.
// Tracks per-register remaining latency, stalls dependants and cancels the
// pending writes of squashed instructions by issue age.
// Optional build macro HAZARD_SB_PERF_EN adds saturating RAW/WAW stall counters.
module hazard_scoreboard
    import hazard_sb_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = $clog2(NREG),
    parameter int unsigned LAT_W  = SB_LAT_W,
    parameter int unsigned SEQ_W  = SB_SEQ_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_wen,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              hold,
    input  logic              flush_valid,
    input  logic [SEQ_W-1:0]  flush_cnt,
    output logic              stall,
    output logic              id_fire,
    output logic [NREG-1:0]   busy_mask
`ifdef HAZARD_SB_PERF_EN
    ,
    output logic [31:0]       perf_raw_stalls,
    output logic [31:0]       perf_waw_stalls
`endif
);

    logic [SEQ_W-1:0] r_seq;
    logic [LAT_W-1:0] w_cnt [NREG];
    logic             w_raw;
    logic             w_waw;
    logic             w_write;

    // r0 is hard-wired and never pending.
    assign w_cnt[0] = '0;

    // An issue only claims an entry when someone must actually wait for it.
    assign w_write = id_fire && id_wen && (id_lat != '0);

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        sb_entry #(
            .LAT_W (LAT_W),
            .SEQ_W (SEQ_W)
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_flush     (flush_valid),
            .i_seq       (r_seq),
            .i_flush_cnt (flush_cnt),
            .i_issue     (w_write && (id_dst == ADDR_W'(g))),
            .i_lat       (id_lat),
            .i_hold      (hold),
            .o_cnt       (w_cnt[g])
        );
    end

    // A source is blocked while its producer has cycles left; a write is
    // blocked while an older write to the same register would land later.
    assign w_raw = (id_rs_used && (id_rs != '0) && (w_cnt[id_rs] != '0)) ||
                   (id_rt_used && (id_rt != '0) && (w_cnt[id_rt] != '0));
    assign w_waw = id_wen && (id_dst != '0) && (w_cnt[id_dst] > id_lat);

    assign stall   = id_valid && (w_raw || w_waw || hold);
    assign id_fire = id_valid && !stall && !flush_valid;

    // Issue sequence: tag handed to the next instruction that fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else if (id_fire) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    // Busy view of the registered counters; bit 0 stays clear.
    always_comb begin
        // NOTE: default first so every bit is assigned on every pass and no
        // latch is inferred for bit 0 or any skipped index.
        busy_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_mask[i] = (w_cnt[i] != '0);
        end
    end

`ifdef HAZARD_SB_PERF_EN
    logic [31:0] r_perf_raw;
    logic [31:0] r_perf_waw;

    // Saturating stall counters; a cycle with both hazards counts as RAW only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_raw <= '0;
            r_perf_waw <= '0;
        end else begin
            if (id_valid && w_raw && (r_perf_raw != 32'hFFFF_FFFF)) begin
                r_perf_raw <= r_perf_raw + 32'd1;
            end
            if (id_valid && w_waw && !w_raw && (r_perf_waw != 32'hFFFF_FFFF)) begin
                r_perf_waw <= r_perf_waw + 32'd1;
            end
        end
    end

    assign perf_raw_stalls = r_perf_raw;
    assign perf_waw_stalls = r_perf_waw;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed table of scenarios,
// hand-written wrap and async-reset sequences, then randomized traffic,
// all compared against an age/countdown reference model.
module tb_hazard_scoreboard;
    import hazard_sb_pkg::*;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_rs_used = 1'b0;
    logic        id_rt_used = 1'b0;
    logic [4:0]  id_dst = '0;
    logic        id_wen = 1'b0;
    logic [2:0]  id_lat = '0;
    logic        hold = 1'b0;
    logic        flush_valid = 1'b0;
    logic [5:0]  flush_cnt = '0;
    logic        stall;
    logic        id_fire;
    logic [31:0] busy_mask;
`ifdef HAZARD_SB_PERF_EN
    logic [31:0] perf_raw_stalls;
    logic [31:0] perf_waw_stalls;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_dst      (id_dst),
        .id_wen      (id_wen),
        .id_lat      (id_lat),
        .hold        (hold),
        .flush_valid (flush_valid),
        .flush_cnt   (flush_cnt),
        .stall       (stall),
        .id_fire     (id_fire),
        .busy_mask   (busy_mask)
`ifdef HAZARD_SB_PERF_EN
        ,
        .perf_raw_stalls (perf_raw_stalls),
        .perf_waw_stalls (perf_waw_stalls)
`endif
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        rs_u;
        logic [4:0]  rt;
        logic        rt_u;
        logic [4:0]  dst;
        logic        wen;
        logic [2:0]  lat;
        logic        hold;
        logic        flush;
        logic [5:0]  fcnt;
        logic        e_stall;
        logic        e_fire;
        logic [31:0] e_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining wait per register and the absolute issue
    // number of its producer; ages are plain integer differences.
    int rem [NREG];
    int iss [NREG];
    int n_issued;
    int m_raw;
    int m_waw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            rem[i] = 0;
            iss[i] = 0;
        end
        n_issued = 0;
        m_raw = 0;
        m_waw = 0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < NREG; i++) b[i] = (rem[i] != 0);
        return b;
    endfunction

    function automatic vec_t mk(int valid, int rs, int rs_u, int dst, int wen, int lat,
                                int hld, int fl, int fcnt, int es, int ef, logic [31:0] eb);
        vec_t v;
        v.valid = 1'(valid);  v.rs = 5'(rs);   v.rs_u = 1'(rs_u);
        v.rt = '0;            v.rt_u = 1'b0;
        v.dst = 5'(dst);      v.wen = 1'(wen); v.lat = 3'(lat);
        v.hold = 1'(hld);     v.flush = 1'(fl); v.fcnt = 6'(fcnt);
        v.e_stall = 1'(es);   v.e_fire = 1'(ef); v.e_busy = eb;
        return v;
    endfunction

    // One clock: drive just after the edge, check combinational outputs at
    // the falling edge, advance the model, check busy_mask after the edge.
    task automatic step(input vec_t v, input bit use_exp, input string tag);
        bit raw, waw, m_stall, m_fire;
        int age;
        id_valid = v.valid;  id_rs = v.rs;   id_rs_used = v.rs_u;
        id_rt = v.rt;        id_rt_used = v.rt_u;
        id_dst = v.dst;      id_wen = v.wen; id_lat = v.lat;
        hold = v.hold;       flush_valid = v.flush; flush_cnt = v.fcnt;
        #4;
        raw = (v.rs_u && v.rs != 0 && rem[v.rs] != 0) || (v.rt_u && v.rt != 0 && rem[v.rt] != 0);
        waw = v.wen && v.dst != 0 && rem[v.dst] > int'(v.lat);
        m_stall = v.valid && (raw || waw || v.hold);
        m_fire  = v.valid && !m_stall && !v.flush;
        check({tag, "_stall"}, 32'(stall), 32'(m_stall));
        check({tag, "_fire"}, 32'(id_fire), 32'(m_fire));
        if (use_exp) begin
            check({tag, "_tbl_stall"}, 32'(stall), 32'(v.e_stall));
            check({tag, "_tbl_fire"}, 32'(id_fire), 32'(v.e_fire));
        end
        if (v.valid && raw) m_raw++;
        if (v.valid && waw && !raw) m_waw++;
        for (int i = 1; i < NREG; i++) begin
            age = n_issued - iss[i];
            if (v.flush && rem[i] != 0 && age >= 1 && age <= int'(v.fcnt)) rem[i] = 0;
            else if (m_fire && v.wen && int'(v.dst) == i && v.lat != 0) begin
                rem[i] = int'(v.lat);
                iss[i] = n_issued;
            end else if (!v.hold && rem[i] != 0) rem[i]--;
        end
        if (m_fire) n_issued++;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, busy_mask, model_busy());
        if (use_exp) check({tag, "_tbl_busy"}, busy_mask, v.e_busy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_valid = 1'b0; hold = 1'b0; flush_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl [$];
    localparam logic [31:0] B5 = 32'h0000_0020;
    localparam logic [31:0] B8 = 32'h0000_0100;
    localparam logic [31:0] B9 = 32'h0000_0200;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        do_reset();
        #3;
        check("reset_busy", busy_mask, 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;

        // Scenario 1: load r5, then a reader.
        tbl.push_back(mk(1, 0, 0, 5, 1, LAT_LOAD, 0, 0, 0, 0, 1, B5));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // Scenario 2: mul r8, reader waits 4 cycles; ALU producer never stalls.
        tbl.push_back(mk(1, 0, 0, 8, 1, LAT_MUL, 0, 0, 0, 0, 1, B8));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, B8));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 3, 1, LAT_ALU, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // Scenario 3: WAW mul r8 then load r8; the load re-tags r8, so a
        // youngest-only flush under hold kills it.
        tbl.push_back(mk(1, 0, 0, 8, 1, LAT_MUL, 0, 0, 0, 0, 1, B8));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 8, 1, LAT_LOAD, 0, 0, 0, 1, 0, B8));
        tbl.push_back(mk(1, 0, 0, 8, 1, LAT_LOAD, 0, 0, 0, 0, 1, B8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        // Scenario 4: flush of the two youngest kills r9; ID is squashed.
        tbl.push_back(mk(1, 0, 0, 9, 1, LAT_MUL, 0, 0, 0, 0, 1, B9));
        tbl.push_back(mk(1, 0, 0, 3, 1, LAT_ALU, 0, 0, 0, 0, 1, B9));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        // Scenario 5: r9 is age 3, outside a 2-deep flush, and keeps counting.
        tbl.push_back(mk(1, 0, 0, 9, 1, LAT_MUL, 0, 0, 0, 0, 1, B9));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, B9));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, B9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, B9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Scenario 6: hold freezes cnt[8]=3 for 2 cycles, then 3 to clear.
        tbl.push_back(mk(1, 0, 0, 8, 1, LAT_MUL, 0, 0, 0, 0, 1, B8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B8));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 8, 1, 0, 0, 0, 1, 0, 0, 1, 0, B8));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, B8));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // r0 destination is never tracked; r0 source never stalls.
        tbl.push_back(mk(1, 0, 0, 0, 1, LAT_DIV, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        foreach (tbl[r]) step(tbl[r], 1'b1, $sformatf("row%0d", r));

`ifdef HAZARD_SB_PERF_EN
        check("perf_raw", perf_raw_stalls, 32'(m_raw));
        check("perf_waw", perf_waw_stalls, 32'(m_waw));
`endif

        // Sequence wrap: 63 plain issues, then r10 (tag 63) and r11 (tag 0);
        // a youngest-only flush kills r11 and spares r10.
        do_reset();
        for (int k = 0; k < 63; k++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "wrap_nop");
        step(mk(1, 0, 0, 10, 1, LAT_DIV, 0, 0, 0, 0, 0, 0), 1'b0, "wrap_r10");
        step(mk(1, 0, 0, 11, 1, LAT_DIV, 0, 0, 0, 0, 0, 0), 1'b0, "wrap_r11");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0, "wrap_flush");
        check("wrap_survivor", busy_mask, 32'h0000_0400);

        // Asynchronous reset in the middle of a countdown.
        step(mk(1, 0, 0, 12, 1, LAT_DIV, 0, 0, 0, 0, 0, 0), 1'b0, "ar_issue");
        id_valid = 1'b1; id_rs = 5'd12; id_rs_used = 1'b1; id_wen = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", busy_mask, 32'h0);
        check("async_reset_stall", 32'(stall), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic on a small register set to provoke hazards.
        for (int k = 0; k < 1500; k++) begin
            v.valid = ($urandom_range(0, 9) < 8);
            v.rs = 5'($urandom_range(0, 7));  v.rs_u = 1'($urandom_range(0, 1));
            v.rt = 5'($urandom_range(0, 7));  v.rt_u = 1'($urandom_range(0, 1));
            v.dst = 5'($urandom_range(0, 7)); v.wen = 1'($urandom_range(0, 1));
            v.lat = 3'($urandom_range(0, 7));
            v.hold = ($urandom_range(0, 7) == 0);
            v.flush = ($urandom_range(0, 9) == 0);
            v.fcnt = 6'($urandom_range(0, 4));
            v.e_stall = 1'b0; v.e_fire = 1'b0; v.e_busy = '0;
            step(v, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
